// File: rtl/pdm_cic_decimator.sv
// ---------------------------------------------------------------------------
// pdm_cic_decimator
//
// Multi-channel 3rd-order CIC decimator: turns NUM_MICS 1-bit PDM streams
// into signed BIT_WIDTH-bit PCM words, one word per channel every
// DEC_FACTOR pdm_ce strobes. All channels share one decimation counter, so
// each output frame is time-aligned across mics.
//
// Ports (top):
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   pdm       in   [NUM_MICS]   PDM bits, sampled only when pdm_ce=1
//   pdm_ce    in   one-cycle sample strobe (>= 5 clk apart)
//   sync_clr  in   synchronous clear of all state (wins over pdm_ce)
//   pcm_data  out  [NUM_MICS*BIT_WIDTH] channel i at [i*BIT_WIDTH +: BIT_WIDTH]
//   pcm_valid out  one-cycle strobe, pcm_data valid while high
//   frame_idx out  [8] frame counter, new value in the pcm_valid cycle
//
// Pipeline: edge E0 samples the last bit of a frame and snapshots
// integrator 3; combs 1..3 follow on E0+1..E0+3, the scaled/saturated word
// is registered on E0+4.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// pdm_cic_lane: one channel of the CIC (integrators, snapshot, combs,
// output scaling and saturation).
//
// Ports:
//   i_clk, i_rst_n  clock / async active-low reset
//   i_clr           synchronous clear of all lane state
//   i_pdm           PDM bit for this channel
//   i_ce            sample enable (already masked by clear)
//   i_snap          capture updated integrator 3 (last sample of a frame)
//   i_en[2:0]       comb stage enables, one per stage, from the valid pipe
//   o_pcm           scaled, saturated comb-3 result (combinational)
// ---------------------------------------------------------------------------
module pdm_cic_lane #(
    parameter int W         = 23,
    parameter int BIT_WIDTH = 8,
    parameter int SHIFT     = 14
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_pdm,
    input  logic                 i_ce,
    input  logic                 i_snap,
    input  logic [2:0]           i_en,
    output logic [BIT_WIDTH-1:0] o_pcm
);
    localparam logic signed [W-1:0] X_POS   = W'(1);
    localparam logic signed [W-1:0] X_NEG   = {W{1'b1}};
    localparam logic signed [W-1:0] SAT_MAX = W'((1 << (BIT_WIDTH-1)) - 1);
    localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [W-1:0] r_i1, r_i2, r_i3;
    logic signed [W-1:0] r_snap;
    logic signed [W-1:0] r_d1, r_d2, r_d3;
    logic signed [W-1:0] r_c1, r_c2, r_c3;

    logic signed [W-1:0] w_x, w_i1n, w_i2n, w_i3n, w_sh;
    logic [BIT_WIDTH-1:0] w_sat;

    // Same-sample cascade: each integrator adds the freshly updated value
    // of the previous one. All sums wrap modulo 2^W; combs undo the wrap.
    assign w_x   = i_pdm ? X_POS : X_NEG;
    assign w_i1n = r_i1 + w_x;
    assign w_i2n = r_i2 + w_i1n;
    assign w_i3n = r_i3 + w_i2n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_i1 <= '0; r_i2 <= '0; r_i3 <= '0; r_snap <= '0;
            r_d1 <= '0; r_d2 <= '0; r_d3 <= '0;
            r_c1 <= '0; r_c2 <= '0; r_c3 <= '0;
        end else if (i_clr) begin
            r_i1 <= '0; r_i2 <= '0; r_i3 <= '0; r_snap <= '0;
            r_d1 <= '0; r_d2 <= '0; r_d3 <= '0;
            r_c1 <= '0; r_c2 <= '0; r_c3 <= '0;
        end else begin
            if (i_ce) begin
                r_i1 <= w_i1n;
                r_i2 <= w_i2n;
                r_i3 <= w_i3n;
                if (i_snap) r_snap <= w_i3n;
            end
            // Each comb's delay register holds the previous decimated input.
            if (i_en[0]) begin
                r_c1 <= r_snap - r_d1;
                r_d1 <= r_snap;
            end
            if (i_en[1]) begin
                r_c2 <= r_c1 - r_d2;
                r_d2 <= r_c1;
            end
            if (i_en[2]) begin
                r_c3 <= r_c2 - r_d3;
                r_d3 <= r_c2;
            end
        end
    end

    // Full scale +/-R^3 lands on +/-2^(BIT_WIDTH-1); +full scale clamps.
    assign w_sh = r_c3 >>> SHIFT;

    always_comb begin
        w_sat = w_sh[BIT_WIDTH-1:0];
        if (w_sh > SAT_MAX)      w_sat = SAT_MAX[BIT_WIDTH-1:0];
        else if (w_sh < SAT_MIN) w_sat = SAT_MIN[BIT_WIDTH-1:0];
    end

    assign o_pcm = w_sat;
endmodule

module pdm_cic_decimator #(
    parameter int NUM_MICS   = 9,
    parameter int BIT_WIDTH  = 8,
    parameter int DEC_FACTOR = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MICS-1:0]           pdm,
    input  logic                          pdm_ce,
    input  logic                          sync_clr,
    output logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data,
    output logic                          pcm_valid,
    output logic [7:0]                    frame_idx
);
    localparam int LOG2R  = $clog2(DEC_FACTOR);
    localparam int W      = 3*LOG2R + 2;
    localparam int SHIFT  = 3*LOG2R - BIT_WIDTH + 1;
    localparam int STAGES = 3;

    localparam logic [LOG2R-1:0] CNT_ONE  = LOG2R'(1);
    localparam logic [LOG2R-1:0] CNT_LAST = LOG2R'(DEC_FACTOR - 1);
    localparam logic [1:0]       PRIME_N  = 2'd2;
    localparam logic [2:0]       GAP_OK   = 3'd4;

    logic [LOG2R-1:0]                     r_dec_cnt;
    logic [STAGES:0]                      r_vld_pipe;
    logic [1:0]                           r_prime;
    logic [2:0]                           r_ce_gap;
    logic                                 w_ce;
    logic                                 w_snap;
    logic [NUM_MICS-1:0][BIT_WIDTH-1:0]   w_pcm;

    // A strobe coincident with sync_clr is discarded.
    assign w_ce   = pdm_ce & ~sync_clr;
    assign w_snap = w_ce && (r_dec_cnt == CNT_LAST);

    for (genvar g = 0; g < NUM_MICS; g++) begin : g_lane
        pdm_cic_lane #(
            .W         (W),
            .BIT_WIDTH (BIT_WIDTH),
            .SHIFT     (SHIFT)
        ) u_lane (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_clr   (sync_clr),
            .i_pdm   (pdm[g]),
            .i_ce    (w_ce),
            .i_snap  (w_snap),
            .i_en    (r_vld_pipe[STAGES-1:0]),
            .o_pcm   (w_pcm[g])
        );
    end

    // r_vld_pipe[0]: snapshot taken; [k]: comb k result ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt  <= '0;
            r_vld_pipe <= '0;
            r_prime    <= '0;
            pcm_data   <= '0;
            pcm_valid  <= 1'b0;
            frame_idx  <= '0;
        end else if (sync_clr) begin
            r_dec_cnt  <= '0;
            r_vld_pipe <= '0;
            r_prime    <= '0;
            pcm_data   <= '0;
            pcm_valid  <= 1'b0;
            frame_idx  <= '0;
        end else begin
            if (w_ce) r_dec_cnt <= r_dec_cnt + CNT_ONE;
            r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_snap};
            pcm_valid  <= 1'b0;
            if (r_vld_pipe[STAGES]) begin
                // The first two outputs carry the CIC start-up transient.
                if (r_prime == PRIME_N) begin
                    pcm_valid <= 1'b1;
                    pcm_data  <= w_pcm;
                    frame_idx <= frame_idx + 8'd1;
                end else begin
                    r_prime <= r_prime + 2'd1;
                end
            end
        end
    end

    // Cycles since the last pdm_ce, saturating; feeds the spacing check only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_ce_gap <= GAP_OK;
        else if (pdm_ce)             r_ce_gap <= '0;
        else if (r_ce_gap != GAP_OK) r_ce_gap <= r_ce_gap + 3'd1;
    end

    a_ce_spacing: assert property (@(posedge clk) disable iff (!rst_n)
        !(pdm_ce && (r_ce_gap < GAP_OK)));
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator at default parameters (9 mics,
// 8-bit PCM, R=128, pdm_ce every 24 clk). Expected words are hand-derived:
// constant 1 -> +2^21 -> 128 -> clamp 0x7F; constant 0 -> 0x80;
// alternating -> 0x00. The first valid word after any clear is frame 3.
module tb_pdm_cic_decimator;
    localparam int NM  = 9;
    localparam int BW  = 8;
    localparam int R   = 128;
    localparam int GAP = 24;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NM-1:0]        pdm = '0;
    logic                 pdm_ce = 1'b0;
    logic                 sync_clr = 1'b0;
    logic [NM*BW-1:0]     pcm_data;
    logic                 pcm_valid;
    logic [7:0]           frame_idx;

    pdm_cic_decimator #(.NUM_MICS(NM), .BIT_WIDTH(BW), .DEC_FACTOR(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pdm       (pdm),
        .pdm_ce    (pdm_ce),
        .sync_clr  (sync_clr),
        .pcm_data  (pcm_data),
        .pcm_valid (pcm_valid),
        .frame_idx (frame_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ce_cyc = 0;
    int mode [NM];           // 0: const 0, 1: const 1, 2: alternating

    logic [NM*BW-1:0] q_data [$];
    logic [7:0]       q_fidx [$];
    int               q_cyc  [$];

    localparam logic [NM*BW-1:0] ALL_7F = {NM{8'h7F}};
    localparam logic [NM*BW-1:0] ALL_80 = {NM{8'h80}};
    localparam logic [NM*BW-1:0] MIXED  = {{(NM-2){8'h00}}, 8'h80, 8'h7F};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Edge counter and pcm_valid capture, sampled 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pcm_valid) begin
                q_data.push_back(pcm_data);
                q_fidx.push_back(frame_idx);
                q_cyc.push_back(cyc);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic flush_q();
        q_data.delete();
        q_fidx.delete();
        q_cyc.delete();
    endtask

    task automatic set_mode(input int m);
        for (int c = 0; c < NM; c++) mode[c] = m;
    endtask

    // One strobe GAP clk after the previous one; last_ce_cyc = sampling edge.
    task automatic send_n(input int n);
        for (int s = 0; s < n; s++) begin
            repeat (GAP-1) @(posedge clk);
            #2;
            for (int c = 0; c < NM; c++)
                pdm[c] = (mode[c] == 1) ? 1'b1 : (mode[c] == 2) ? s[0] : 1'b0;
            pdm_ce = 1'b1;
            @(posedge clk);
            #2;
            pdm_ce = 1'b0;
            last_ce_cyc = cyc;
        end
    endtask

    task automatic do_clr();
        @(posedge clk);
        #2 sync_clr = 1'b1;
        @(posedge clk);
        #2 sync_clr = 1'b0;
        flush_q();
    endtask

    task automatic expect_one(input string tag, input logic [NM*BW-1:0] exp_d, input logic [7:0] exp_f);
        chk({tag, "_count"}, 128'(q_data.size()), 128'd1);
        if (q_data.size() > 0) begin
            chk({tag, "_data"}, 128'(q_data[0]), 128'(exp_d));
            chk({tag, "_fidx"}, 128'(q_fidx[0]), 128'(exp_f));
        end
    endtask

    initial begin
        set_mode(1);
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",  128'(pcm_data),  128'd0);
        chk("rst_valid", 128'(pcm_valid), 128'd0);
        chk("rst_fidx",  128'(frame_idx), 128'd0);
        #1 rst_n = 1'b1;
        flush_q();

        // all ones: priming, latency, clamp to 0x7F, hold
        send_n(2*R);
        wait_cyc(8);
        chk("ones_prime", 128'(q_data.size()), 128'd0);
        send_n(R);
        wait_cyc(8);
        expect_one("ones_f3", ALL_7F, 8'd1);
        if (q_cyc.size() > 0)
            chk("ones_latency", 128'(q_cyc[0] - last_ce_cyc), 128'd4);
        chk("ones_hold_data",  128'(pcm_data),  128'(ALL_7F));
        chk("ones_hold_valid", 128'(pcm_valid), 128'd0);

        // all zeros -> 0x80
        do_clr();
        set_mode(0);
        send_n(3*R);
        wait_cyc(8);
        expect_one("zeros_f3", ALL_80, 8'd1);

        // alternating -> 0x00, strobes exactly R*GAP apart, frame_idx 1,2
        do_clr();
        set_mode(2);
        send_n(4*R);
        wait_cyc(8);
        chk("alt_count", 128'(q_data.size()), 128'd2);
        if (q_data.size() >= 2) begin
            chk("alt_data0", 128'(q_data[0]), 128'd0);
            chk("alt_data1", 128'(q_data[1]), 128'd0);
            chk("alt_fidx0", 128'(q_fidx[0]), 128'd1);
            chk("alt_fidx1", 128'(q_fidx[1]), 128'd2);
            chk("alt_spacing", 128'(q_cyc[1] - q_cyc[0]), 128'(R*GAP));
        end

        // channel independence, then a clear that kills an in-flight word
        do_clr();
        set_mode(2);
        mode[0] = 1;
        mode[1] = 0;
        send_n(3*R);
        wait_cyc(8);
        expect_one("indep_f3", MIXED, 8'd1);
        flush_q();
        send_n(R);
        #1 sync_clr = 1'b1;       // sampled at E0+1, pipeline in flight
        @(posedge clk);
        #2 sync_clr = 1'b0;
        wait_cyc(8);
        chk("clr_kill_count", 128'(q_data.size()), 128'd0);
        chk("clr_kill_fidx",  128'(frame_idx),     128'd0);

        // sync_clr at dec_cnt=60 coincident with pdm_ce
        do_clr();
        set_mode(1);
        send_n(60);
        repeat (GAP-1) @(posedge clk);
        #2;
        pdm_ce = 1'b1;
        sync_clr = 1'b1;
        @(posedge clk);
        #2;
        pdm_ce = 1'b0;
        sync_clr = 1'b0;
        flush_q();
        send_n(2*R);
        wait_cyc(8);
        chk("sclr_prime", 128'(q_data.size()), 128'd0);
        send_n(R);
        wait_cyc(8);
        expect_one("sclr_f3", ALL_7F, 8'd1);
        if (q_cyc.size() > 0)
            chk("sclr_latency", 128'(q_cyc[0] - last_ce_cyc), 128'd4);

        // rst_n pulsed low between E0 and E0+4
        flush_q();
        send_n(R);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data",  128'(pcm_data),  128'd0);
        chk("arst_valid", 128'(pcm_valid), 128'd0);
        chk("arst_fidx",  128'(frame_idx), 128'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(8);
        chk("arst_no_valid", 128'(q_data.size()), 128'd0);
        chk("arst_data_after", 128'(pcm_data), 128'd0);
        send_n(2*R);
        wait_cyc(8);
        chk("arst_prime", 128'(q_data.size()), 128'd0);
        send_n(R);
        wait_cyc(8);
        expect_one("arst_f3", ALL_7F, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

Multi-channel 3rd-order CIC decimator that converts the 1-bit PDM streams from the microphone array into signed BIT_WIDTH-bit PCM samples. It replaces the free-running per-mic accumulators. It sits between the PDM sampling point (strobed by the PDM clock divider) and the per-mic sample FIFOs and beamformer. All channels share one decimation counter, so every output word for a given frame is time-aligned across mics.

## Interface
- NUM_MICS, 9, number of PDM channels
- BIT_WIDTH, 8, signed PCM output width per channel
- DEC_FACTOR, 128, decimation ratio R; must be a power of two, 8..256
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  reset; asynchronous, active-low
- pdm  in  NUM_MICS  PDM bits, one per mic; sampled only when pdm_ce=1
- pdm_ce  in  1  one-cycle sample strobe, aligned with the rising edge of pdm_clk
- sync_clr  in  1  synchronous clear of all filter state; same effect as reset, but clocked
- pcm_data  out  NUM_MICS*BIT_WIDTH  channel i occupies bits [i*BIT_WIDTH +: BIT_WIDTH], two's complement
- pcm_valid  out  1  one-cycle strobe; pcm_data is valid while this is high
- frame_idx  out  8  frame counter; increments with each pcm_valid

## Operation
- Input mapping: pdm bit 1 maps to +1 and bit 0 maps to −1, sign-extended to the internal width W = 3*log2(DEC_FACTOR)+2. With the defaults, W = 23.
- Integrators: three cascaded integrators per channel. All of them update only on cycles with pdm_ce=1. They wrap modulo 2^W; this wrap is intended and must not be saturated.
- dec_cnt: a shared counter, 0..DEC_FACTOR−1, that advances on each pdm_ce. When pdm_ce=1 with dec_cnt=DEC_FACTOR−1, the updated integrator-3 value is snapshotted into the comb pipeline and dec_cnt wraps to 0.
- Combs: three cascaded comb stages per channel, differential delay 1, at the decimated rate. There is one register stage per comb, so it advances one stage per clk after the snapshot. Comb arithmetic is modulo 2^W.
- Output scaling: y = comb3 >>> (3*log2(DEC_FACTOR) − BIT_WIDTH + 1), arithmetic shift. The result is then saturated to [−2^(BIT_WIDTH−1), 2^(BIT_WIDTH−1)−1].
  - Default full scale is ±2^21, which shifts to ±128.
  - +128 clamps to 127.
- Priming: the first 2 decimated outputs after reset or sync_clr are computed but suppressed. They produce no pcm_valid and no frame_idx change. The prime counter saturates after 2.
- frame_idx: increments modulo 256 on each pcm_valid, and carries the new value in the same cycle as that pcm_valid.
- No backpressure. The consumer must accept each word in its pcm_valid cycle.

## Timing
- Reset values: pcm_data=0, pcm_valid=0, frame_idx=0. Internal reset state is also all zero: integrators, combs, dec_cnt and prime counter.
- Latency: let E0 be the clk edge that samples the last pdm bit of a frame (pdm_ce=1, dec_cnt=DEC_FACTOR−1). pcm_valid and pcm_data are registered at edge E0+4, and pcm_valid is high for exactly one cycle.
- pcm_data holds its value between pcm_valid strobes.
- pdm_ce spacing must be at least 5 clk cycles. Behaviour with closer strobes is undefined; the assertion checker flags it.
- sync_clr=1 takes priority over pdm_ce in the same cycle. That cycle's pdm sample is discarded.
- sync_clr also kills any in-flight comb pipeline result, so no pcm_valid is produced from a pre-clear frame.
- Reset asserted mid-frame or mid-pipeline clears everything immediately; this is asynchronous. Release is synchronous to the clk design convention.
- pdm is ignored on cycles with pdm_ce=0.

## Test plan
- All mics held at pdm=1, pdm_ce every 24 clk, defaults:
  - no pcm_valid for the first 2 frames;
  - 3rd frame onward: every channel = 0x7F;
  - frame_idx = 1, 2, 3, …
- All mics held at 0: settled output on every channel = 0x80 (−128).
- All mics driving alternating 1/0 PDM: settled output = 0x00 on all channels. Pulse spacing is exactly DEC_FACTOR*24 clk.
- Channel independence:
  - ch0 = 1, ch1 = 0, ch2..8 alternating;
  - expect 0x7F / 0x80 / 0x00 in the correct slices, no cross-talk.
- Latency check: pcm_valid is seen exactly 4 edges after the final pdm_ce edge of frame 3.
- Clears, each followed by re-checking priming (2 suppressed frames) and frame_idx restarting at 1:
  - sync_clr asserted at dec_cnt=60 and coincident with a pdm_ce → no pcm_valid from the interrupted frame;
  - rst_n pulsed low between E0 and E0+4 → pcm_valid is never seen and outputs read 0.
